// File: rtl/fifo_pkg.sv
// Shared FIFO constants and the pointer helper used by the read-side drain stage.
package fifo_pkg;
   localparam int DATA_SIZE = 8;
   localparam int ADDR_SIZE = 4;
   localparam int BUF_DEPTH = 3;

   typedef logic [1:0] buf_ptr_t;

   // Pointers wrap 2 -> 0 because the buffer depth is not a power of two.
   function automatic buf_ptr_t ptr_inc(input buf_ptr_t p);
      return (p == buf_ptr_t'(BUF_DEPTH - 1)) ? buf_ptr_t'(0) : p + buf_ptr_t'(1);
   endfunction
endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Three-entry circular buffer with occupancy count; head is always visible on head_data.
// Push and pop may coincide at any occupancy; a pushed word is never bypassed to the head.
module fifo_rd_skid_buf #(
   parameter int DATA_SIZE = fifo_pkg::DATA_SIZE
) (
   input  logic                 rd_clk,
   input  logic                 rd_rst,
   input  logic                 push,
   input  logic [DATA_SIZE-1:0] push_data,
   input  logic                 pop,
   output logic [DATA_SIZE-1:0] head_data,
   output logic [1:0]           count
);
   import fifo_pkg::*;

   buf_ptr_t             wr_ptr;
   buf_ptr_t             rd_ptr;
   logic [DATA_SIZE-1:0] mem [BUF_DEPTH];

   always_ff @(posedge rd_clk or negedge rd_rst) begin
      if (!rd_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   // Storage is left unreset; count alone decides what is valid.
   always_ff @(posedge rd_clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign head_data = mem[rd_ptr];
endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the FIFO read port into a framed valid/ready stream; 2 cycles from fifo_rd_en to out_valid.
// Read issue depends only on registered occupancy, so out_ready never reaches fifo_rd_en combinationally.
module fifo_rd_stream #(
   parameter int DATA_SIZE = fifo_pkg::DATA_SIZE,
   parameter int PKT_LEN   = 4
) (
   input  logic                 rd_clk,
   input  logic                 rd_rst,
   input  logic                 fifo_empty,
   input  logic [DATA_SIZE-1:0] fifo_rd_data,
   output logic                 fifo_rd_en,
   output logic                 out_valid,
   output logic [DATA_SIZE-1:0] out_data,
   output logic                 out_last,
   input  logic                 out_ready,
   output logic [15:0]          pkt_count
);
   import fifo_pkg::*;

   localparam logic [7:0] LAST_BEAT = 8'(PKT_LEN - 1);

   logic [1:0] count;
   logic       inflight;
   logic [7:0] beat;
   logic [2:0] occupancy;
   logic       room;
   logic       pop;
   logic       last_beat;

   // Words already buffered plus the one still coming back from the FIFO.
   assign occupancy  = {1'b0, count} + {2'b00, inflight};
   assign room       = occupancy < 3'(BUF_DEPTH);
   assign fifo_rd_en = !fifo_empty && room;

   assign out_valid  = (count != 2'd0);
   assign pop        = out_valid && out_ready;
   assign last_beat  = (beat == LAST_BEAT);
   assign out_last   = out_valid && last_beat;

   fifo_rd_skid_buf #(
      .DATA_SIZE (DATA_SIZE)
   ) u_buf (
      .rd_clk    (rd_clk),
      .rd_rst    (rd_rst),
      .push      (inflight),
      .push_data (fifo_rd_data),
      .pop       (pop),
      .head_data (out_data),
      .count     (count)
   );

   always_ff @(posedge rd_clk or negedge rd_rst) begin
      if (!rd_rst) begin
         inflight  <= 1'b0;
         beat      <= '0;
         pkt_count <= '0;
      end else begin
         inflight <= fifo_rd_en;
         if (pop) begin
            if (last_beat) begin
               beat      <= '0;
               pkt_count <= pkt_count + 16'd1;
            end else begin
               beat <= beat + 8'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a FIFO model, a word scoreboard and a PKT_LEN=1 wrap instance.
module tb_fifo_rd_stream;
   localparam int PKT_LEN = 4;
   localparam int WRAP_WORDS = 65537;

   logic rd_clk = 1'b0;
   always #5 rd_clk = ~rd_clk;

   logic        rd_rst;
   logic        hold_empty;
   logic        fifo_empty;
   logic [7:0]  fifo_rd_data;
   logic        fifo_rd_en;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_last;
   logic        out_ready;
   logic [15:0] pkt_count;

   logic        rst2;
   logic        fifo_empty2;
   logic [7:0]  fifo_rd_data2;
   logic        fifo_rd_en2;
   logic        out_valid2;
   logic [7:0]  out_data2;
   logic        out_last2;
   logic        out_ready2 = 1'b1;
   logic [15:0] pkt_count2;

   int checks = 0;
   int errors = 0;

   fifo_rd_stream #(.DATA_SIZE(8), .PKT_LEN(PKT_LEN)) u_dut (
      .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
      .fifo_rd_en(fifo_rd_en), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
      .out_ready(out_ready), .pkt_count(pkt_count));

   fifo_rd_stream #(.DATA_SIZE(8), .PKT_LEN(1)) u_wrap (
      .rd_clk(rd_clk), .rd_rst(rst2), .fifo_empty(fifo_empty2), .fifo_rd_data(fifo_rd_data2),
      .fifo_rd_en(fifo_rd_en2), .out_valid(out_valid2), .out_data(out_data2), .out_last(out_last2),
      .out_ready(out_ready2), .pkt_count(pkt_count2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // FIFO model: one-cycle read latency, flushed with the read-side reset.
   logic [7:0] fmem [0:1023];
   int wr_idx = 0;
   int rd_idx = 0;
   logic [7:0] exp_q [$];

   assign fifo_empty = hold_empty || (rd_idx == wr_idx);

   always @(posedge rd_clk or negedge rd_rst) begin
      if (!rd_rst) rd_idx <= wr_idx;
      else if (fifo_rd_en) begin
         fifo_rd_data <= fmem[rd_idx[9:0]];
         rd_idx       <= rd_idx + 1;
      end
   end

   task automatic push_word(input logic [7:0] w);
      fmem[wr_idx[9:0]] = w;
      wr_idx++;
      exp_q.push_back(w);
   endtask

   task automatic step();
      @(posedge rd_clk);
      #1;
   endtask

   // Scoreboard and occupancy model; sampled mid-cycle, each sample is the pop at the next edge.
   int   beat_m = 0;
   int   occ_m  = 0;
   logic infl_m = 1'b0;
   int   viol   = 0;
   int   ovf    = 0;

   always begin
      @(negedge rd_clk or negedge rd_rst);
      if (!rd_rst) begin
         exp_q.delete();
         beat_m = 0;
         occ_m  = 0;
         infl_m = 1'b0;
      end else begin
         if (fifo_rd_en && fifo_empty) viol++;
         if (out_valid && out_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
               errors++;
               $error("FAIL sb_extra_word observed=%0h expected=none", out_data);
            end
            if (exp_q.size() != 0) begin
               chk("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
               chk("sb_last", 32'(out_last), (beat_m == PKT_LEN - 1) ? 1 : 0);
            end
            beat_m = (beat_m == PKT_LEN - 1) ? 0 : beat_m + 1;
         end
         occ_m = occ_m + (infl_m ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
         if (occ_m > 3) ovf++;
         infl_m = fifo_rd_en;
      end
   end

   // Wrap instance: endless source of incrementing words, limited to WRAP_WORDS reads.
   int         rem2 = WRAP_WORDS;
   logic [7:0] src2 = 8'd0;
   int         pops2 = 0;
   int         lastmiss2 = 0;
   int         dataerr2 = 0;
   int         viol2 = 0;
   logic [7:0] exp2 = 8'd0;

   assign fifo_empty2 = (rem2 == 0);

   always @(posedge rd_clk or negedge rst2) begin
      if (!rst2) begin
         rem2 <= WRAP_WORDS;
         src2 <= 8'd0;
      end else if (fifo_rd_en2) begin
         fifo_rd_data2 <= src2;
         src2          <= src2 + 8'd1;
         rem2          <= rem2 - 1;
      end
   end

   always begin
      @(negedge rd_clk);
      if (rst2) begin
         if (fifo_rd_en2 && fifo_empty2) viol2++;
         if (out_valid2 && out_ready2) begin
            pops2++;
            if (!out_last2) lastmiss2++;
            if (out_data2 !== exp2) dataerr2++;
            exp2 = exp2 + 8'd1;
         end
      end
   end

   initial begin
      int rdcnt;
      rd_rst     = 1'b0;
      rst2       = 1'b0;
      hold_empty = 1'b1;
      out_ready  = 1'b0;
      repeat (3) step();
      chk("rst_rd_en", 32'(fifo_rd_en), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_last", 32'(out_last), 0);
      chk("rst_pkt_count", 32'(pkt_count), 0);
      rd_rst = 1'b1;
      rst2   = 1'b1;

      // Empty at start, then streaming of 0x01..0x08.
      for (int i = 1; i <= 8; i++) push_word(8'(i));
      out_ready = 1'b1;
      for (int i = 0; i < 50; i++) begin
         chk("empty_rd_en", 32'(fifo_rd_en), 0);
         chk("empty_valid", 32'(out_valid), 0);
         step();
      end
      hold_empty = 1'b0;
      #1;
      chk("first_rd_en", 32'(fifo_rd_en), 1);
      step();
      chk("latency_valid_n1", 32'(out_valid), 0);
      step();
      for (int i = 0; i < 8; i++) begin
         chk("stream_valid", 32'(out_valid), 1);
         chk("stream_data", 32'(out_data), i + 1);
         chk("stream_last", 32'(out_last), (i % 4 == 3) ? 1 : 0);
         step();
      end
      chk("stream_idle", 32'(out_valid), 0);
      chk("stream_pkt_count", 32'(pkt_count), 2);

      // Backpressure: 10 words with the sink stalled for 20 cycles.
      out_ready = 1'b0;
      for (int i = 1; i <= 10; i++) push_word(8'(i));
      rdcnt = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (fifo_rd_en) rdcnt++;
         step();
      end
      chk("bp_reads", 32'(rdcnt), 3);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_hold_data", 32'(out_data), 8'h01);
      chk("bp_hold_last", 32'(out_last), 0);
      out_ready = 1'b1;
      #1;
      chk("bp_full_no_rd", 32'(fifo_rd_en), 0);
      step();
      chk("bp_restart_rd", 32'(fifo_rd_en), 1);
      for (int i = 0; i < 100 && !(exp_q.size() == 0 && !out_valid); i++) step();
      chk("bp_drained", 32'(exp_q.size()), 0);
      chk("bp_pkt_count", 32'(pkt_count), 4);

      // Toggled ready against a random empty pattern.
      for (int i = 0; i < 256; i++) push_word(8'((i * 37 + 5) & 8'hff));
      for (int i = 0; i < 4000 && !(exp_q.size() == 0 && !out_valid); i++) begin
         out_ready  = ~out_ready;
         hold_empty = ($urandom_range(0, 2) == 0);
         step();
      end
      hold_empty = 1'b0;
      out_ready  = 1'b1;
      chk("tog_drained", 32'(exp_q.size()), 0);
      chk("tog_pkt_count", 32'(pkt_count), 68);

      // Two pad words realign the packet boundary.
      push_word(8'h71);
      push_word(8'h72);
      for (int i = 0; i < 20 && !(exp_q.size() == 0 && !out_valid); i++) step();
      chk("pad_pkt_count", 32'(pkt_count), 69);

      // Mid-packet reset with two words buffered at beat 2.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_word(8'hA0 + 8'(i));
      repeat (10) step();
      out_ready = 1'b1;
      step();
      step();
      out_ready = 1'b0;
      step();
      chk("pre_rst_valid", 32'(out_valid), 1);
      chk("pre_rst_data", 32'(out_data), 8'hA2);
      rd_rst = 1'b0;
      #1;
      chk("rst_async_valid", 32'(out_valid), 0);
      chk("rst_async_pkt", 32'(pkt_count), 0);
      step();
      step();
      rd_rst = 1'b1;
      for (int i = 0; i < 4; i++) push_word(8'hB0 + 8'(i));
      out_ready = 1'b1;
      for (int i = 0; i < 10 && !out_valid; i++) step();
      chk("post_rst_data", 32'(out_data), 8'hB0);
      chk("post_rst_last", 32'(out_last), 0);
      for (int i = 0; i < 20 && !(exp_q.size() == 0 && !out_valid); i++) step();
      chk("post_rst_drained", 32'(exp_q.size()), 0);
      chk("post_rst_pkt", 32'(pkt_count), 1);
      chk("rd_en_on_empty", 32'(viol), 0);
      chk("overflow", 32'(ovf), 0);

      // Counter wrap on the PKT_LEN=1 instance.
      for (int i = 0; i < 70000 && pops2 < WRAP_WORDS; i++) step();
      repeat (4) step();
      chk("wrap_pops", 32'(pops2), WRAP_WORDS);
      chk("wrap_pkt_count", 32'(pkt_count2), 1);
      chk("wrap_last_every_beat", 32'(lastmiss2), 0);
      chk("wrap_data_order", 32'(dataerr2), 0);
      chk("wrap_rd_en_on_empty", 32'(viol2), 0);
      chk("wrap_idle", 32'(out_valid2), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
